mdr_mem_ctrl: RTL

Parametrised memory data register with a built-in memory handshake controller for the Mini SRC datapath. It holds the MDR value driven onto the bus and loads it either from the internal bus or from memory. It also issues request/acknowledge transactions to the memory port, with byte/halfword/word sizing, sign or zero extension, and a timeout error. It sits between the bus multiplexer and the memory subsystem, replacing the single-cycle MDR.

---
 rtl/mdr_pkg.sv | 19 +
 rtl/mdr_extend.sv | 32 +++
 rtl/mdr_mem_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mdr_pkg.sv
// Shared types and constants for the Mini SRC memory data register
// and its memory handshake controller.
package mdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mdr_extend.sv
// Sign/zero extension of a lane-0 aligned byte or halfword to the full data width.
// Purely combinational so the future load unit can reuse it.
module mdr_extend
    import mdr_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            size,
    input  logic                  signExt,
    output logic [DATA_WIDTH-1:0] extData
);

    // Bits above the selected lane are filled with either the lane's MSB or zero.
    always_comb begin
        extData = data;
        case (size)
            SZ_BYTE: begin
                for (int i = 8; i < DATA_WIDTH; i++) begin
                    extData[i] = signExt & data[7];
                end
            end
            SZ_HALF: begin
                for (int i = 16; i < DATA_WIDTH; i++) begin
                    extData[i] = signExt & data[15];
                end
            end
            default: extData = data;
        endcase
    end

endmodule

// File: rtl/mdr_mem_ctrl.sv
// Memory data register with a request/acknowledge memory port controller:
// sized reads with extension, writes of the MDR value, and a sticky timeout error.
module mdr_mem_ctrl
    import mdr_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TIMEOUT    = DEFAULT_TIMEOUT,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
    input  logic                    Clock,
    input  logic                    Clear,
    input  logic                    MDRin,
    input  logic [DATA_WIDTH-1:0]   BusMuxOut,
    input  logic                    Read,
    input  logic                    Write,
    input  logic [1:0]              Size,
    input  logic                    Signed,
    output logic [DATA_WIDTH-1:0]   BusMuxIn,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Err
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t                  state, stateNext;
    logic [DATA_WIDTH-1:0]   mdr, mdrNext;
    logic                    reqNext, weNext, busyNext, doneNext, errNext;
    logic [BE_W-1:0]         beNext;
    logic [CNT_W-1:0]        count, countNext;
    logic [1:0]              sizeLatched, sizeNext;
    logic                    signedLatched, signedNext;
    logic [DATA_WIDTH-1:0]   readExtended;

    mdr_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) extendUnit (
        .data    (mem_rdata),
        .size    (sizeLatched),
        .signExt (signedLatched),
        .extData (readExtended)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state         <= IDLE;
            mdr           <= INIT;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_be        <= '0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Err           <= 1'b0;
            count         <= '0;
            sizeLatched   <= SZ_WORD;
            signedLatched <= 1'b0;
        end else begin
            state         <= stateNext;
            mdr           <= mdrNext;
            mem_req       <= reqNext;
            mem_we        <= weNext;
            mem_be        <= beNext;
            Busy          <= busyNext;
            Done          <= doneNext;
            Err           <= errNext;
            count         <= countNext;
            sizeLatched   <= sizeNext;
            signedLatched <= signedNext;
        end
    end

    // Read has priority over Write and over MDRin; an ack arriving on the
    // expiry cycle still completes the transaction successfully.
    always_comb begin
        stateNext  = state;
        mdrNext    = mdr;
        reqNext    = mem_req;
        weNext     = mem_we;
        beNext     = mem_be;
        busyNext   = Busy;
        doneNext   = 1'b0;
        errNext    = Err;
        countNext  = count;
        sizeNext   = sizeLatched;
        signedNext = signedLatched;

        case (state)
            IDLE: begin
                if (Read || Write) begin
                    stateNext  = Read ? RD : WR;
                    weNext     = !Read;
                    reqNext    = 1'b1;
                    busyNext   = 1'b1;
                    errNext    = 1'b0;
                    countNext  = '0;
                    sizeNext   = Size;
                    signedNext = Signed;
                    case (Size)
                        SZ_BYTE: beNext = BE_W'(1);
                        SZ_HALF: beNext = BE_W'(3);
                        default: beNext = '1;
                    endcase
                end else if (MDRin) begin
                    mdrNext = BusMuxOut;
                end
            end
            RD, WR: begin
                if (mem_ack) begin
                    if (state == RD) begin
                        mdrNext = readExtended;
                    end
                    stateNext = IDLE;
                    reqNext   = 1'b0;
                    weNext    = 1'b0;
                    beNext    = '0;
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                end else if ((TIMEOUT > 0) && (count == CNT_LAST)) begin
                    stateNext = IDLE;
                    reqNext   = 1'b0;
                    weNext    = 1'b0;
                    beNext    = '0;
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                    errNext   = 1'b1;
                end else begin
                    countNext = count + CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign BusMuxIn  = mdr;
    assign mem_wdata = mdr;

endmodule
